// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared mode encoding, default round counts and controller
//               state type for the AES round controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    localparam logic [1:0] c_mode_128     = 2'b00;
    localparam logic [1:0] c_mode_192     = 2'b01;
    localparam logic [1:0] c_mode_256     = 2'b10;
    localparam logic [1:0] c_mode_illegal = 2'b11;

    localparam int unsigned c_nr_128_def = 10;
    localparam int unsigned c_nr_192_def = 12;
    localparam int unsigned c_nr_256_def = 14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_LAST  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Illegal mode never reaches the datapath, so its round count is a don't-care.
    function automatic logic [3:0] nr_of(input logic [1:0] mode,
                                         input logic [3:0] n128,
                                         input logic [3:0] n192,
                                         input logic [3:0] n256);
        logic [3:0] nr;
        case (mode)
            c_mode_192: nr = n192;
            c_mode_256: nr = n256;
            default:    nr = n128;
        endcase
        return nr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_rr_arb2.sv
// ============================================================================
// Module      : aes_rr_arb2
// Description : Two-way round-robin arbiter; pointer advances on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic [1:0] o_grant,
    output logic       o_gnt_id
);

    logic r_last;

    // Last-granted starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

    always_comb begin
        o_grant  = 2'b00;
        o_gnt_id = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_id = ~r_last;
            o_grant  = r_last ? 2'b01 : 2'b10;
        end else if (i_req[1]) begin
            o_gnt_id = 1'b1;
            o_grant  = 2'b10;
        end else if (i_req[0]) begin
            o_gnt_id = 1'b0;
            o_grant  = 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : Round sequencer for a shared iterative AES datapath serving
//               two requesters. Optional job counter: AES_ROUND_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NR_128 = c_nr_128_def,
    parameter int unsigned NR_192 = c_nr_192_def,
    parameter int unsigned NR_256 = c_nr_256_def
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_mode,
    input  logic [1:0]  req_dec,
    output logic        dp_load,
    output logic        dp_round_en,
    output logic        dp_final,
    output logic [3:0]  dp_round_idx,
    output logic        dp_dec,
    output logic        dp_src,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_err,
`ifdef AES_ROUND_CTRL_PERF_EN
    output logic [15:0] jobs_done,
`endif
    input  logic        rsp_ready,
    output logic        busy
);

    state_t     r_state;
    state_t     w_nxt;
    logic       r_id;
    logic       r_dec;
    logic       r_err;
    logic [3:0] r_nr;
    logic [3:0] r_idx;

    logic [1:0] w_arb_req;
    logic [1:0] w_grant;
    logic       w_gnt_id;
    logic [1:0] w_sel_mode;
    logic       w_sel_dec;
    logic [3:0] w_sel_nr;
    logic       w_accept;
    logic       w_rsp_hs;
    logic [3:0] w_round_end;

    // Requests are masked while busy so the arbiter cannot grant mid-job.
    assign w_arb_req = (r_state == ST_IDLE) ? req_valid : 2'b00;

    aes_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (reset),
        .i_req    (w_arb_req),
        .i_upd    (w_rsp_hs),
        .i_upd_id (r_id),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id)
    );

    assign w_accept    = (r_state == ST_IDLE) && (|req_valid);
    assign w_rsp_hs    = (r_state == ST_HOLD) && rsp_ready;
    assign w_sel_mode  = w_gnt_id ? req_mode[3:2] : req_mode[1:0];
    assign w_sel_dec   = req_dec[w_gnt_id];
    assign w_sel_nr    = nr_of(w_sel_mode, 4'(NR_128), 4'(NR_192), 4'(NR_256));
    assign w_round_end = r_dec ? 4'd1 : (r_nr - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_id    <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
            r_nr    <= 4'd0;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_id  <= w_gnt_id;
                r_dec <= w_sel_dec;
                r_err <= (w_sel_mode == c_mode_illegal);
                r_nr  <= w_sel_nr;
                r_idx <= w_sel_dec ? w_sel_nr : 4'd0;
            end else if ((r_state == ST_LOAD) || (r_state == ST_ROUND)) begin
                // Index walks toward the final key; LAST then sees 0 or Nr.
                r_idx <= r_dec ? (r_idx - 4'd1) : (r_idx + 4'd1);
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nxt = (w_sel_mode == c_mode_illegal) ? ST_HOLD : ST_LOAD;
                end
            end
            ST_LOAD:  w_nxt = (r_nr == 4'd1) ? ST_LAST : ST_ROUND;
            ST_ROUND: begin
                if (r_idx == w_round_end) begin
                    w_nxt = ST_LAST;
                end
            end
            ST_LAST:  w_nxt = ST_HOLD;
            ST_HOLD: begin
                if (rsp_ready) begin
                    w_nxt = ST_IDLE;
                end
            end
            default:  w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = w_accept ? w_grant : 2'b00;
        dp_load      = (r_state == ST_LOAD);
        dp_round_en  = (r_state == ST_ROUND) || (r_state == ST_LAST);
        dp_final     = (r_state == ST_LAST);
        dp_round_idx = (dp_load || dp_round_en) ? r_idx : 4'd0;
        busy         = (r_state != ST_IDLE);
        dp_dec       = busy ? r_dec : 1'b0;
        dp_src       = busy ? r_id : 1'b0;
        rsp_valid    = (r_state == ST_HOLD);
        rsp_id       = rsp_valid ? r_id : 1'b0;
        rsp_err      = rsp_valid ? r_err : 1'b0;
    end

`ifdef AES_ROUND_CTRL_PERF_EN
    logic [15:0] r_jobs_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jobs_done <= 16'd0;
        end else if (w_rsp_hs && !r_err) begin
            r_jobs_done <= r_jobs_done + 16'd1;
        end
    end

    assign jobs_done = r_jobs_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Self-checking bench for aes_round_ctrl (directed + random jobs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_mode;
    logic [1:0]  req_dec;
    logic        dp_load;
    logic        dp_round_en;
    logic        dp_final;
    logic [3:0]  dp_round_idx;
    logic        dp_dec;
    logic        dp_src;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;
`ifdef AES_ROUND_CTRL_PERF_EN
    logic [15:0] jobs_done;
    int          exp_jobs = 0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_last;

    aes_round_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_dec      (req_dec),
        .dp_load      (dp_load),
        .dp_round_en  (dp_round_en),
        .dp_final     (dp_final),
        .dp_round_idx (dp_round_idx),
        .dp_dec       (dp_dec),
        .dp_src       (dp_src),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
`ifdef AES_ROUND_CTRL_PERF_EN
        .jobs_done    (jobs_done),
`endif
        .rsp_ready    (rsp_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({req_ready, dp_load, dp_round_en, dp_final, dp_round_idx, dp_dec,
                      dp_src, rsp_valid, rsp_id, rsp_err, busy}), 32'd0);
    endtask

    // One complete job from IDLE: expectations derive from job parameters and cycle offset.
    task automatic run_job(input logic [1:0] v, input logic [3:0] m, input logic [1:0] d,
                           input int dly, input bit scramble);
        logic [1:0] g;
        logic       id;
        logic [1:0] jm;
        logic       jd;
        logic       err;
        logic       hold;
        logic [2:0] es;
        logic [3:0] ei;
        int         nr;
        int         k;
        int         hc;
        bit         done;
        req_valid = v;
        req_mode  = m;
        req_dec   = d;
        g   = (v == 2'b11) ? (exp_last ? 2'b01 : 2'b10) : v;
        id  = g[1];
        jm  = id ? m[3:2] : m[1:0];
        jd  = d[id];
        err = (jm == 2'b11);
        nr  = (jm == 2'b00) ? 10 : (jm == 2'b01) ? 12 : 14;
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(g));
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        k    = 1;
        hc   = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            hold = err || (k >= nr + 2);
            es   = 3'b000;
            ei   = 4'd0;
            if (!hold) begin
                if (k == 1) begin
                    es = 3'b100;
                    ei = jd ? 4'(nr) : 4'd0;
                end else if (k <= nr) begin
                    es = 3'b010;
                    ei = jd ? 4'(nr - (k - 1)) : 4'(k - 1);
                end else begin
                    es = 3'b011;
                    ei = jd ? 4'd0 : 4'(nr);
                end
            end
            chk("strobes", 32'({dp_load, dp_round_en, dp_final}), 32'(es));
            chk("round_idx", 32'(dp_round_idx), 32'(ei));
            chk("dec_src", 32'({dp_dec, dp_src}), 32'({jd, id}));
            chk("rsp", 32'({rsp_valid, rsp_id, rsp_err}),
                hold ? 32'({1'b1, id, err}) : 32'd0);
            chk("busy_ready", 32'({busy, req_ready}), 32'b100);
            if (scramble) begin
                req_valid = 2'($urandom);
                req_mode  = 4'($urandom);
                req_dec   = 2'($urandom);
            end
            if (hold) begin
                rsp_ready = (hc >= dly);
                hc++;
            end
            @(posedge clk);
            #1;
            if (rsp_ready) begin
                done      = 1'b1;
                rsp_ready = 1'b0;
                exp_last  = id;
`ifdef AES_ROUND_CTRL_PERF_EN
                if (!err) exp_jobs = (exp_jobs + 1) & 16'hFFFF;
`endif
            end
            k++;
        end
        if (!done) chk("job_timeout", 32'd0, 32'd1);
`ifdef AES_ROUND_CTRL_PERF_EN
        chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_mode  = 4'b0000;
        req_dec   = 2'b00;
        rsp_ready = 1'b0;
        exp_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 128-bit cipher on requester 0; 256-bit decipher on requester 1
        run_job(2'b01, 4'b0000, 2'b00, 0, 1'b0);
        run_job(2'b10, 4'b1000, 2'b10, 0, 1'b0);
        // Both held: grants alternate
        for (int i = 0; i < 4; i++) run_job(2'b11, 4'b0000, 2'b00, 0, 1'b0);
        // Illegal mode on requester 0
        run_job(2'b01, 4'b0011, 2'b00, 0, 1'b0);
        // Consumer stalls 5 cycles in HOLD while requests toggle
        run_job(2'b01, 4'b0001, 2'b01, 5, 1'b1);

        // Reset pulse mid-ROUND aborts the job
        req_valid = 2'b01;
        req_mode  = 4'b0000;
        req_dec   = 2'b00;
        @(negedge clk);
        chk("abort_grant", 32'(req_ready), 32'(exp_last ? 2'b01 : 2'b01));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_in_round", 32'(dp_round_en), 32'd1);
        reset     = 1'b1;
        req_valid = 2'b00;
        #1;
        chk_all_zero("abort_outputs");
        #2;
        reset    = 1'b0;
        exp_last = 1'b1;
`ifdef AES_ROUND_CTRL_PERF_EN
        exp_jobs = 0;
`endif
        @(posedge clk);
        #1;
        run_job(2'b11, 4'b0101, 2'b11, 1, 1'b0);

        // Randomized jobs
        for (int i = 0; i < 30; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run_job(v, 4'($urandom), 2'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR_128, default 10: round count for 128-bit key jobs.
REQ-002 Parameter NR_192, default 12: round count for 192-bit key jobs.
REQ-003 Parameter NR_256, default 14: round count for 256-bit key jobs.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester job request; bit n = requester n.
REQ-007 req_ready  out  2  one-hot accept pulse to the granted requester.
REQ-008 req_mode  in  4  {mode1,mode0}; 00=128, 01=192, 10=256, 11=illegal.
REQ-009 req_dec  in  2  per-requester direction; 1=decipher, 0=cipher.
REQ-010 dp_load  out  1  datapath loads input block XOR round key dp_round_idx.
REQ-011 dp_round_en  out  1  datapath executes one round this cycle.
REQ-012 dp_final  out  1  current round is the final round (no MixColumns).
REQ-013 dp_round_idx  out  4  round-key index presented to the datapath.
REQ-014 dp_dec  out  1  direction of the active job.
REQ-015 dp_src  out  1  requester id whose data the datapath muxes in.
REQ-016 rsp_valid  out  1  result block ready on datapath output.
REQ-017 rsp_id  out  1  requester id owning the result.
REQ-018 rsp_err  out  1  job rejected for illegal mode; qualified by rsp_valid.
REQ-019 rsp_ready  in  1  consumer accepts result.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, ROUND, LAST, HOLD.
REQ-022 IDLE: any req_valid high -> grant one requester, assert its req_ready for exactly that cycle, capture mode/dec/id; go LOAD (or HOLD with rsp_err=1 if mode=11).
REQ-023 Arbitration SHALL be round-robin: both valid -> grant requester != last granted; single valid -> grant it.
REQ-024 Last-granted pointer SHALL update only on rsp handshake (rsp_valid & rsp_ready), including error responses.
REQ-025 Nr SHALL be NR_128/NR_192/NR_256 from captured mode.
REQ-026 LOAD (1 cycle): dp_load=1, dp_round_idx = dec ? Nr : 0.
REQ-027 ROUND (Nr-1 cycles): dp_round_en=1; idx 1..Nr-1 ascending (cipher) or Nr-1..1 descending (decipher).
REQ-028 LAST (1 cycle): dp_round_en=1, dp_final=1, idx = dec ? 0 : Nr.
REQ-029 Latency: accept at cycle T -> LOAD T+1, LAST T+Nr+1, rsp_valid first high T+Nr+2 (T+12 for 128-bit).
REQ-030 HOLD: rsp_valid held with stable rsp_id/rsp_err until rsp_ready; handshake -> IDLE next cycle; no same-cycle re-grant.
REQ-031 dp_src, dp_dec SHALL remain stable from LOAD through HOLD.
REQ-032 req_valid changes outside IDLE SHALL be ignored; no request is accepted while busy.
REQ-033 Illegal-mode job SHALL never assert dp_load or dp_round_en.
REQ-034 dp_* strobes SHALL be 0 in IDLE and HOLD.

Reset
REQ-035 reset SHALL force IDLE asynchronously; all outputs 0; pointer set so requester 0 wins first tie.
REQ-036 reset mid-job SHALL abort it with no response; the job is lost.

Configuration
REQ-037 Macro AES_ROUND_CTRL_PERF_EN defined: add output jobs_done (16 bits), reset 0, +1 per rsp handshake with rsp_err=0, wraps 0xFFFF->0.
REQ-038 Macro undefined: jobs_done port and counter absent; all other behaviour identical.

Structure
REQ-039 Package aes_ctrl_pkg SHALL hold the mode encoding, NR defaults, FSM state enum.
REQ-040 Sub-module aes_rr_arb2 SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-041 req_valid=01, mode0=00, dec0=0, rsp_ready=1 -> idx 0,1..9,10 with dp_final only at 10; rsp_valid at T+12, rsp_id=0.
REQ-042 req_valid=10, mode1=10, dec1=1 -> idx 14,13..1,0; rsp_valid at T+16, rsp_id=1.
REQ-043 req_valid=11 held, all 128-bit -> grants alternate 0,1,0,1; rsp_id matches.
REQ-044 mode0=11 -> no dp strobes, rsp_valid at T+1 with rsp_err=1; jobs_done unchanged.
REQ-045 rsp_ready=0 for 5 cycles in HOLD -> rsp_valid/rsp_id stable, req_ready stays 00.
REQ-046 reset pulsed during ROUND -> outputs 0, busy=0 immediately; next request served normally.
